psum_drain_collector: RTL and testbench

- Consumer at the psum output edge of the configurable dummy PE array; receives the NUM_COLS-lane bottom-row psum vector under a valid/ready handshake.
- Accumulates NUM_PASSES consecutive vectors per lane (multi-pass row-stationary reduction), then queues the finished vector in a small FIFO.
- Serialises each queued vector onto a single-lane ofmap stream for the output global buffer writer, one column per handshake.

---
 rtl/pe_array_pkg.sv | 22 ++
 rtl/psum_vec_fifo.sv | 67 ++++++
 rtl/psum_drain_collector.sv | 148 ++++++++++++++
 tb/tb_psum_drain_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array psum drain path.
// - Default lane widths and the matching lane typedefs.
// - Serializer state enum.
// - clog2_min1(): index width that never collapses to zero bits.
package pe_array_pkg;

  localparam int unsigned DefaultPeWidth   = 4;
  localparam int unsigned DefaultNumCols   = 3;
  localparam int unsigned DefaultAccWidth  = 8;
  localparam int unsigned DefaultNumPasses = 3;
  localparam int unsigned DefaultFifoDepth = 4;

  typedef logic [DefaultPeWidth-1:0]  psum_lane_t;
  typedef logic [DefaultAccWidth-1:0] acc_lane_t;

  typedef enum logic [0:0] {S_IDLE, S_SEND} ser_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_vec_fifo.sv
// Synchronous circular-buffer FIFO holding finished psum vectors.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i/wdata_i  write one entry (ignored when full)
//   pop_i/rdata_o   rdata_o shows the head; pop_i retires it (ignored when empty)
//   full_o, empty_o, count_o  occupancy status, all derived from registered count
module psum_vec_fifo
  import pe_array_pkg::*;
#(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = clog2_min1(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    rdata_o = mem_q[rptr_q];
    count_o = count_q;
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    // Depth is a power of two, so pointers wrap by plain overflow.
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/psum_drain_collector.sv
// Collects bottom-row psum vectors from the PE array, accumulates NUM_PASSES
// vectors per lane, queues finished vectors and serialises them one lane per beat.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   psum_valid_in/psum_in        incoming psum vector (NUM_COLS lanes)
//   psum_ready_out               vector accepted when high with psum_valid_in
//   ofmap_data/col_idx/last      serialised accumulated lane, its index, last flag
//   ofmap_valid/ofmap_ready      output handshake
//   fifo_count                   finished vectors waiting in the queue
module psum_drain_collector
  import pe_array_pkg::*;
#(
  parameter int unsigned PE_WIDTH   = DefaultPeWidth,
  parameter int unsigned NUM_COLS   = DefaultNumCols,
  parameter int unsigned ACC_WIDTH  = DefaultAccWidth,
  parameter int unsigned NUM_PASSES = DefaultNumPasses,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                psum_valid_in,
  input  logic [PE_WIDTH-1:0]                 psum_in [NUM_COLS],
  output logic                                psum_ready_out,
  output logic [ACC_WIDTH-1:0]                ofmap_data,
  output logic [clog2_min1(NUM_COLS)-1:0]     ofmap_col_idx,
  output logic                                ofmap_last,
  output logic                                ofmap_valid,
  input  logic                                ofmap_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);

  localparam int unsigned ColW  = clog2_min1(NUM_COLS);
  localparam int unsigned PassW = clog2_min1(NUM_PASSES);
  localparam int unsigned VecW  = NUM_COLS * ACC_WIDTH;
  localparam logic [PassW-1:0] LastPass = PassW'(NUM_PASSES - 1);
  localparam logic [ColW-1:0]  LastCol  = ColW'(NUM_COLS - 1);

  typedef logic [ACC_WIDTH-1:0] acc_t;

  logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
  acc_t             acc_q [NUM_COLS];
  acc_t             acc_d [NUM_COLS];
  acc_t             lane_sum [NUM_COLS];
  logic             final_pass, capture, push, pop;
  logic             fifo_full, fifo_empty;
  logic [VecW-1:0]  push_vec, head_vec;

  ser_state_e       state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  acc_t             out_vec_q [NUM_COLS];
  acc_t             out_vec_d [NUM_COLS];

  // Accumulator. acc is cleared after every final pass, so pass 0 is simply
  // 0 + psum and no separate load path is needed.
  always_comb begin
    final_pass     = (pass_cnt_q == LastPass);
    // Registered full flag only: a pop in this cycle does not open a slot.
    psum_ready_out = rst & ~(final_pass & fifo_full);
    capture        = psum_valid_in & psum_ready_out;
    push           = capture & final_pass;
    pass_cnt_d     = pass_cnt_q;
    for (int i = 0; i < NUM_COLS; i++) begin
      lane_sum[i] = acc_q[i] + ACC_WIDTH'(psum_in[i]);
      push_vec[i*ACC_WIDTH +: ACC_WIDTH] = lane_sum[i];
      acc_d[i] = acc_q[i];
      if (capture) acc_d[i] = final_pass ? '0 : lane_sum[i];
    end
    if (capture) pass_cnt_d = final_pass ? '0 : pass_cnt_q + 1'b1;
  end

  // Serializer next state; the last beat pops the next head directly so
  // queued vectors stream without a bubble.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pop     = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) out_vec_d[i] = out_vec_q[i];
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          col_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ofmap_ready) begin
          if (col_q != LastCol) begin
            col_d = col_q + 1'b1;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            col_d = '0;
          end else begin
            col_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      for (int i = 0; i < NUM_COLS; i++) out_vec_d[i] = head_vec[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_comb begin
    ofmap_valid   = (state_q == S_SEND);
    ofmap_col_idx = col_q;
    ofmap_data    = ofmap_valid ? out_vec_q[col_q] : '0;
    ofmap_last    = ofmap_valid && (col_q == LastCol);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt_q <= '0;
      state_q    <= S_IDLE;
      col_q      <= '0;
      for (int i = 0; i < NUM_COLS; i++) begin
        acc_q[i]     <= '0;
        out_vec_q[i] <= '0;
      end
    end else begin
      pass_cnt_q <= pass_cnt_d;
      state_q    <= state_d;
      col_q      <= col_d;
      for (int i = 0; i < NUM_COLS; i++) begin
        acc_q[i]     <= acc_d[i];
        out_vec_q[i] <= out_vec_d[i];
      end
    end
  end

  psum_vec_fifo #(
    .Width(VecW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push),
    .wdata_i(push_vec),
    .pop_i  (pop),
    .rdata_o(head_vec),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed bench for psum_drain_collector: default instance plus an
// ACC_WIDTH=5 instance for modulo wraparound.
module tb_psum_drain_collector;
  import pe_array_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  logic       psum_valid_in;
  psum_lane_t psum_in [3];
  logic       psum_ready_out;
  logic [7:0] ofmap_data;
  logic [1:0] ofmap_col_idx;
  logic       ofmap_last, ofmap_valid, ofmap_ready;
  logic [2:0] fifo_count;

  logic       valid5;
  psum_lane_t psum5 [3];
  logic       ready_out5;
  logic [4:0] data5;
  logic [1:0] col5;
  logic       last5, ovalid5, oready5;
  logic [2:0] count5;

  int n_checks = 0;
  int n_pass = 0;
  int overflow_hits = 0;
  int beat_data[$];
  int beat_col[$];
  int beat_last[$];

  psum_drain_collector dut (
    .clk(clk), .rst(rst), .psum_valid_in(psum_valid_in), .psum_in(psum_in),
    .psum_ready_out(psum_ready_out), .ofmap_data(ofmap_data), .ofmap_col_idx(ofmap_col_idx),
    .ofmap_last(ofmap_last), .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready),
    .fifo_count(fifo_count)
  );

  psum_drain_collector #(
    .PE_WIDTH(4), .NUM_COLS(3), .ACC_WIDTH(5), .NUM_PASSES(3), .FIFO_DEPTH(4)
  ) dut5 (
    .clk(clk), .rst(rst), .psum_valid_in(valid5), .psum_in(psum5),
    .psum_ready_out(ready_out5), .ofmap_data(data5), .ofmap_col_idx(col5),
    .ofmap_last(last5), .ofmap_valid(ovalid5), .ofmap_ready(oready5),
    .fifo_count(count5)
  );

  always @(posedge clk) if (fifo_count > 3'd4) overflow_hits <= overflow_hits + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int a, input int b, input int c);
    psum_in[0] = psum_lane_t'(a);
    psum_in[1] = psum_lane_t'(b);
    psum_in[2] = psum_lane_t'(c);
  endtask

  task automatic feed(input int a, input int b, input int c);
    set_vec(a, b, c);
    psum_valid_in = 1'b1;
    step();
    psum_valid_in = 1'b0;
  endtask

  task automatic drain(input int n, input int max_cyc);
    beat_data.delete(); beat_col.delete(); beat_last.delete();
    ofmap_ready = 1'b1;
    for (int c = 0; c < max_cyc && beat_data.size() < n; c++) begin
      if (ofmap_valid) begin
        beat_data.push_back(int'(ofmap_data));
        beat_col.push_back(int'(ofmap_col_idx));
        beat_last.push_back(int'(ofmap_last));
      end
      step();
    end
  endtask

  task automatic test_reset();
    psum_valid_in = 1'b1; ofmap_ready = 1'b1; set_vec(1, 1, 1);
    valid5 = 1'b0; oready5 = 1'b0;
    for (int i = 0; i < 3; i++) psum5[i] = '0;
    #3;
    n_checks++; if (psum_ready_out !== 1'b0) $display("FAIL rst_ready: got %b expected 0", psum_ready_out); else n_pass++;
    n_checks++; if (ofmap_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", ofmap_valid); else n_pass++;
    n_checks++; if (ofmap_data !== 8'd0) $display("FAIL rst_data: got %0d expected 0", ofmap_data); else n_pass++;
    n_checks++; if (ofmap_last !== 1'b0) $display("FAIL rst_last: got %b expected 0", ofmap_last); else n_pass++;
    n_checks++; if (ofmap_col_idx !== 2'd0) $display("FAIL rst_col: got %0d expected 0", ofmap_col_idx); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d expected 0", fifo_count); else n_pass++;
    step(); step();
    psum_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (psum_ready_out !== 1'b1) $display("FAIL rel_ready: got %b expected 1", psum_ready_out); else n_pass++;
  endtask

  task automatic test_basic();
    ofmap_ready = 1'b1;
    for (int p = 0; p < 3; p++) feed(1, 2, 3);
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL basic_count: got %0d expected 1", fifo_count); else n_pass++;
    n_checks++; if (ofmap_valid !== 1'b0) $display("FAIL basic_lat1: got %b expected 0", ofmap_valid); else n_pass++;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ofmap_valid !== 1'b1) $display("FAIL basic_valid%0d: got %b expected 1", i, ofmap_valid); else n_pass++;
      n_checks++; if (ofmap_data !== 8'(3 * (i + 1))) $display("FAIL basic_data%0d: got %0d expected %0d", i, ofmap_data, 3 * (i + 1)); else n_pass++;
      n_checks++; if (ofmap_col_idx !== 2'(i)) $display("FAIL basic_col%0d: got %0d expected %0d", i, ofmap_col_idx, i); else n_pass++;
      n_checks++; if (ofmap_last !== (i == 2)) $display("FAIL basic_last%0d: got %b expected %b", i, ofmap_last, i == 2); else n_pass++;
      step();
    end
    n_checks++; if (ofmap_valid !== 1'b0) $display("FAIL basic_idle: got %b expected 0", ofmap_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    oready5 = 1'b1;
    for (int i = 0; i < 3; i++) psum5[i] = psum_lane_t'(15);
    valid5 = 1'b1;
    step(); step(); step();
    valid5 = 1'b0;
    n_checks++; if (count5 !== 3'd1) $display("FAIL wrap_count: got %0d expected 1", count5); else n_pass++;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ovalid5 !== 1'b1 || data5 !== 5'd13 || col5 !== 2'(i) || last5 !== (i == 2))
        $display("FAIL wrap_beat%0d: got v=%b d=%0d c=%0d l=%b expected v=1 d=13 c=%0d l=%b",
                 i, ovalid5, data5, col5, last5, i, i == 2);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    ofmap_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      for (int p = 0; p < 3; p++) begin
        n_checks++; if (psum_ready_out !== 1'b1) $display("FAIL bp_ready_v%0d_p%0d: got %b expected 1", k, p, psum_ready_out); else n_pass++;
        feed(k, k + 1, k + 2);
        if (k >= 2) begin
          n_checks++; if (ofmap_valid !== 1'b1 || ofmap_data !== 8'd3 || ofmap_col_idx !== 2'd0)
            $display("FAIL bp_hold: got v=%b d=%0d c=%0d expected v=1 d=3 c=0", ofmap_valid, ofmap_data, ofmap_col_idx);
          else n_pass++;
        end
      end
      n_checks++; if (fifo_count !== 3'((k == 1) ? 1 : k - 1)) $display("FAIL bp_count_v%0d: got %0d expected %0d", k, fifo_count, (k == 1) ? 1 : k - 1); else n_pass++;
    end
    for (int p = 0; p < 2; p++) begin
      n_checks++; if (psum_ready_out !== 1'b1) $display("FAIL bp_ready_v6_p%0d: got %b expected 1", p, psum_ready_out); else n_pass++;
      feed(6, 7, 8);
    end
    set_vec(6, 7, 8);
    psum_valid_in = 1'b1;
    #1;
    n_checks++; if (psum_ready_out !== 1'b0) $display("FAIL bp_stall: got %b expected 0", psum_ready_out); else n_pass++;
    step(); step();
    n_checks++; if (psum_ready_out !== 1'b0 || fifo_count !== 3'd4) $display("FAIL bp_stall_hold: got r=%b n=%0d expected r=0 n=4", psum_ready_out, fifo_count); else n_pass++;
    beat_data.delete(); beat_col.delete(); beat_last.delete();
    ofmap_ready = 1'b1;
    for (int c = 0; c < 100 && beat_data.size() < 18; c++) begin
      if (!seen && psum_valid_in && psum_ready_out) begin
        seen = 1;
        n_checks++; if (beat_data.size() !== 3) $display("FAIL bp_reopen: got %0d beats expected 3", beat_data.size()); else n_pass++;
      end
      if (ofmap_valid) begin
        beat_data.push_back(int'(ofmap_data));
        beat_col.push_back(int'(ofmap_col_idx));
        beat_last.push_back(int'(ofmap_last));
      end
      step();
      if (seen) psum_valid_in = 1'b0;
    end
    psum_valid_in = 1'b0;
    n_checks++; if (seen !== 1'b1) $display("FAIL bp_reassert: got %b expected 1", seen); else n_pass++;
    n_checks++; if (beat_data.size() !== 18) $display("FAIL bp_beats: got %0d expected 18", beat_data.size()); else n_pass++;
    for (int i = 0; i < beat_data.size() && i < 18; i++) begin
      n_checks++; if (beat_data[i] !== 3 * (i / 3 + 1) + 3 * (i % 3) || beat_col[i] !== i % 3 || beat_last[i] !== int'(i % 3 == 2))
        $display("FAIL bp_order%0d: got d=%0d c=%0d l=%0d expected d=%0d c=%0d l=%0d", i, beat_data[i], beat_col[i],
                 beat_last[i], 3 * (i / 3 + 1) + 3 * (i % 3), i % 3, int'(i % 3 == 2));
      else n_pass++;
    end
    n_checks++; if (overflow_hits !== 0) $display("FAIL bp_overflow: got %0d expected 0", overflow_hits); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_d[6] = '{3, 6, 9, 15, 15, 15};
    ofmap_ready = 1'b0;
    for (int p = 0; p < 3; p++) feed(1, 2, 3);
    for (int p = 0; p < 3; p++) feed(5, 5, 5);
    step();
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL b2b_count: got %0d expected 1", fifo_count); else n_pass++;
    ofmap_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (ofmap_valid !== 1'b1 || ofmap_data !== 8'(exp_d[i]) || ofmap_col_idx !== 2'(i % 3))
        $display("FAIL b2b_beat%0d: got v=%b d=%0d c=%0d expected v=1 d=%0d c=%0d", i, ofmap_valid, ofmap_data,
                 ofmap_col_idx, exp_d[i], i % 3);
      else n_pass++;
      step();
    end
    n_checks++; if (ofmap_valid !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", ofmap_valid); else n_pass++;
  endtask

  task automatic test_input_stall();
    ofmap_ready = 1'b1;
    feed(1, 1, 1);
    set_vec(15, 15, 15); step();
    feed(2, 2, 2);
    set_vec(15, 15, 15); step();
    feed(4, 4, 4);
    drain(3, 20);
    n_checks++; if (beat_data.size() !== 3) $display("FAIL stall_beats: got %0d expected 3", beat_data.size()); else n_pass++;
    for (int i = 0; i < beat_data.size(); i++) begin
      n_checks++; if (beat_data[i] !== 7) $display("FAIL stall_data%0d: got %0d expected 7", i, beat_data[i]); else n_pass++;
    end
    n_checks++; if (ofmap_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL stall_idle: got v=%b n=%0d expected v=0 n=0", ofmap_valid, fifo_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    ofmap_ready = 1'b1;
    feed(5, 5, 5); feed(5, 5, 5);
    #2; rst = 1'b0; #1;
    n_checks++; if (psum_ready_out !== 1'b0 || ofmap_valid !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL mid_rst1: got r=%b v=%b n=%0d expected r=0 v=0 n=0", psum_ready_out, ofmap_valid, fifo_count);
    else n_pass++;
    step(); rst = 1'b1;
    for (int p = 0; p < 3; p++) feed(2, 2, 2);
    for (int c = 0; c < 20 && !found; c++) begin
      if (ofmap_valid && ofmap_col_idx == 2'd1) found = 1; else step();
    end
    n_checks++; if (found !== 1'b1) $display("FAIL mid_col1: got %b expected 1", found); else n_pass++;
    n_checks++; if (ofmap_data !== 8'd6) $display("FAIL mid_data: got %0d expected 6", ofmap_data); else n_pass++;
    #2; rst = 1'b0; #1;
    n_checks++; if (ofmap_valid !== 1'b0 || ofmap_data !== 8'd0 || ofmap_col_idx !== 2'd0 || ofmap_last !== 1'b0 ||
                    fifo_count !== 3'd0 || psum_ready_out !== 1'b0)
      $display("FAIL mid_rst2: got v=%b d=%0d c=%0d l=%b n=%0d r=%b expected all 0", ofmap_valid, ofmap_data,
               ofmap_col_idx, ofmap_last, fifo_count, psum_ready_out);
    else n_pass++;
    step(); rst = 1'b1;
    for (int p = 0; p < 3; p++) feed(1, 1, 1);
    drain(4, 20);
    n_checks++; if (beat_data.size() !== 3) $display("FAIL mid_beats: got %0d expected 3", beat_data.size()); else n_pass++;
    for (int i = 0; i < beat_data.size(); i++) begin
      n_checks++; if (beat_data[i] !== 3) $display("FAIL mid_data%0d: got %0d expected 3", i, beat_data[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_input_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
